// File: rtl/jtcps_rom_nslots.sv
// N-slot ROM read cache: each slot keeps one word; misses are arbitrated round-robin onto one SDRAM port.
// Hit latency 0 cycles (combinational slot_ok); refill takes one request handshake plus 1 or 2 data beats.
module jtcps_rom_nslots #(
  parameter int SDRAMW = 23,
  parameter int SLOTS  = 4,
  parameter int AW     = 22,
  parameter int DW     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SLOTS-1:0]        slot_cs,
  input  logic [SLOTS-1:0]        slot_clr,
  input  logic [SLOTS*AW-1:0]     slot_addr,
  input  logic [SLOTS*SDRAMW-1:0] offset,
  output logic [SLOTS-1:0]        slot_ok,
  output logic [SLOTS*DW-1:0]     slot_dout,
  output logic [SDRAMW-1:0]       sdram_addr,
  output logic                    sdram_req,
  input  logic                    sdram_ack,
  input  logic                    data_dst,
  input  logic                    data_rdy,
  input  logic [15:0]             data_read
);

  localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int SW = (DW == 32) ? 32 : 16;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, gnt, gsel;
  logic              found, beat, drop, last, fill;
  logic [AW-1:0]     gnt_tag;
  logic [15:0]       lo_buf;
  logic [SW-1:0]     fill_dat;
  logic [SLOTS-1:0]  valid, hit, cand;
  logic [AW-1:0]     tag      [SLOTS];
  logic [SW-1:0]     data     [SLOTS];
  logic [AW-1:0]     key      [SLOTS];
  logic [SDRAMW-1:0] addr_calc[SLOTS];
  int                idx;

  wire unused_ok = &{1'b0, data_dst, lo_buf};

  // Byte-wide slots share one 16-bit SDRAM word between two adjacent addresses
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (DW == 8) begin : g_byte
      assign key[gi] = {1'b0, slot_addr[gi*AW+1 +: AW-1]};
      assign slot_dout[gi*DW +: DW] = slot_addr[gi*AW] ? data[gi][15:8] : data[gi][7:0];
    end else begin : g_word
      assign key[gi] = slot_addr[gi*AW +: AW];
      assign slot_dout[gi*DW +: DW] = data[gi][DW-1:0];
    end
    assign addr_calc[gi] = offset[gi*SDRAMW +: SDRAMW] + SDRAMW'(key[gi]);
    assign hit[gi]  = valid[gi] && (tag[gi] == key[gi]);
    assign cand[gi] = slot_cs[gi] & ~hit[gi] & ~slot_clr[gi];
  end

  if (DW == 32) begin : g_fill32
    assign fill_dat = {data_read, lo_buf};
  end else begin : g_fill16
    assign fill_dat = data_read;
  end

  assign slot_ok   = slot_cs & hit;
  assign sdram_req = (state == REQ);
  assign last      = data_rdy && (beat || DW != 32);
  assign fill      = (state == WAIT) && last && !drop && !slot_clr[gnt];

  // Round-robin search starting at ptr
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = 0;
    for (int k = 0; k < SLOTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= SLOTS) idx = idx - SLOTS;
      if (!found && cand[idx]) begin
        found = 1'b1;
        gsel  = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)     state_nxt = REQ;
      REQ:     if (sdram_ack) state_nxt = WAIT;
      WAIT:    if (last)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      gnt_tag    <= '0;
      sdram_addr <= '0;
      beat       <= 1'b0;
      drop       <= 1'b0;
      lo_buf     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (found) begin
          gnt        <= gsel;
          gnt_tag    <= key[gsel];
          sdram_addr <= addr_calc[gsel];
          ptr        <= (gsel == PW'(SLOTS-1)) ? '0 : gsel + 1'b1;
          drop       <= 1'b0;
        end
        REQ: begin
          if (sdram_ack)     beat <= 1'b0;
          if (slot_clr[gnt]) drop <= 1'b1;
        end
        WAIT: begin
          if (data_rdy) begin
            beat   <= 1'b1;
            lo_buf <= data_read;
          end
          if (slot_clr[gnt]) drop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A clear always beats a refill landing on the same slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (slot_clr[i]) begin
          valid[i] <= 1'b0;
        end else if (fill && gnt == PW'(i)) begin
          valid[i] <= 1'b1;
          tag[i]   <= gnt_tag;
          data[i]  <= fill_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcps_rom_nslots.sv
// Directed bench: 4-slot 32-bit instance for refill/arbitration/clear/reset/wrap, 2-slot 8-bit instance for byte select.
module tb_jtcps_rom_nslots;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   slot_cs, slot_clr, slot_ok;
  logic [87:0]  slot_addr;
  logic [91:0]  offset;
  logic [127:0] slot_dout;
  logic [22:0]  sdram_addr;
  logic         sdram_req, sdram_ack, data_dst, data_rdy;
  logic [15:0]  data_read;

  logic [1:0]   b_cs, b_clr, b_ok;
  logic [43:0]  b_addr;
  logic [45:0]  b_offset;
  logic [15:0]  b_dout;
  logic [22:0]  b_sdram_addr;
  logic         b_req, b_ack, b_rdy;
  logic [15:0]  b_read;

  int checks = 0;
  int passed = 0;

  jtcps_rom_nslots #(.SDRAMW(23), .SLOTS(4), .AW(22), .DW(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .slot_cs(slot_cs), .slot_clr(slot_clr),
    .slot_addr(slot_addr), .offset(offset), .slot_ok(slot_ok), .slot_dout(slot_dout),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read));

  jtcps_rom_nslots #(.SDRAMW(23), .SLOTS(2), .AW(22), .DW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .slot_cs(b_cs), .slot_clr(b_clr),
    .slot_addr(b_addr), .offset(b_offset), .slot_ok(b_ok), .slot_dout(b_dout),
    .sdram_addr(b_sdram_addr), .sdram_req(b_req), .sdram_ack(b_ack),
    .data_dst(data_dst), .data_rdy(b_rdy), .data_read(b_read));

  task automatic set_slot(input int i, input logic [21:0] a, input logic [22:0] off);
    slot_addr[i*22 +: 22] = a;
    offset[i*23 +: 23]    = off;
  endtask

  task automatic clear_all();
    @(posedge clk); #1;
    slot_cs  = 4'h0;
    slot_clr = 4'hf;
    @(posedge clk); #1;
    slot_clr = 4'h0;
  endtask

  task automatic wait_req(output logic seen);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sdram_req) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_txn(input logic [15:0] b0, input logic [15:0] b1, output logic dropped);
    sdram_ack = 1'b1;
    @(posedge clk); #1;
    sdram_ack = 1'b0;
    dropped   = !sdram_req;
    data_rdy  = 1'b1;
    data_read = b0;
    @(posedge clk); #1;
    data_read = b1;
    @(posedge clk); #1;
    data_rdy  = 1'b0;
  endtask

  task automatic serve(input logic [15:0] b0, input logic [15:0] b1,
                       output logic seen, output logic [22:0] a, output logic dropped);
    wait_req(seen);
    a       = sdram_addr;
    dropped = 1'b0;
    if (seen) finish_txn(b0, b1, dropped);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    checks++; if (sdram_req !== 1'b0) $display("FAIL reset_req: got %b want 0", sdram_req); else passed++;
    checks++; if (sdram_addr !== 23'h0) $display("FAIL reset_addr: got %h want 0", sdram_addr); else passed++;
    checks++; if (slot_ok !== 4'h0) $display("FAIL reset_ok: got %b want 0000", slot_ok); else passed++;
    checks++; if (slot_dout !== 128'h0) $display("FAIL reset_dout: got %h want 0", slot_dout); else passed++;
    checks++; if (b_req !== 1'b0 || b_ok !== 2'b00) $display("FAIL reset_dut8: req %b ok %b want 0 00", b_req, b_ok); else passed++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_miss_refill();
    logic seen, dropped;
    logic [22:0] a;
    int reqs;
    @(posedge clk); #1;
    set_slot(1, 22'h10, 23'h100);
    slot_cs = 4'b0010;
    @(negedge clk);
    checks++; if (slot_ok[1] !== 1'b0) $display("FAIL miss_ok_before: got %b want 0", slot_ok[1]); else passed++;
    serve(16'h1234, 16'hABCD, seen, a, dropped);
    checks++; if (seen !== 1'b1 || a !== 23'h110) $display("FAIL miss_req_addr: seen %b addr %h want 1 110", seen, a); else passed++;
    checks++; if (dropped !== 1'b1) $display("FAIL miss_req_drop: got %b want 1", dropped); else passed++;
    checks++; if (slot_ok !== 4'b0010) $display("FAIL miss_ok_after: got %b want 0010", slot_ok); else passed++;
    checks++; if (slot_dout[63:32] !== 32'hABCD1234) $display("FAIL miss_dout: got %h want abcd1234", slot_dout[63:32]); else passed++;
    reqs = 0;
    repeat (6) begin
      @(negedge clk);
      if (sdram_req) reqs++;
    end
    checks++; if (reqs !== 0 || slot_ok[1] !== 1'b1) $display("FAIL hit_no_req: reqs %0d ok %b want 0 1", reqs, slot_ok[1]); else passed++;
  endtask

  task automatic rr_round(input int first, input string name);
    logic seen, dropped;
    logic [22:0] a, want;
    int s;
    for (int r = 0; r < 4; r++) begin
      s = (first + r) % 4;
      want = 23'h1000 * 23'(s + 1) + 23'(s);
      serve(16'(s), 16'h5A00, seen, a, dropped);
      checks++; if (seen !== 1'b1 || a !== want) $display("FAIL %s_grant%0d: seen %b addr %h want 1 %h", name, r, seen, a, want); else passed++;
    end
  endtask

  task automatic test_round_robin();
    logic seen, dropped;
    logic [22:0] a;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_slot(i, 22'(i), 23'h1000 * 23'(i + 1));
    slot_cs = 4'hf;
    rr_round(0, "rr1");
    checks++; if (slot_ok !== 4'hf) $display("FAIL rr1_all_ok: got %b want 1111", slot_ok); else passed++;
    clear_all();
    slot_cs = 4'b0010;
    serve(16'h0, 16'h0, seen, a, dropped);
    checks++; if (seen !== 1'b1 || a !== 23'h2001) $display("FAIL rr_setup: seen %b addr %h want 1 2001", seen, a); else passed++;
    slot_cs  = 4'h0;
    slot_clr = 4'b0010;
    @(posedge clk); #1;
    slot_clr = 4'h0;
    slot_cs  = 4'hf;
    rr_round(2, "rr2");
  endtask

  task automatic test_clear_midflight();
    logic seen, dropped;
    logic [22:0] a;
    @(posedge clk); #1;
    slot_cs  = 4'h0;
    slot_clr = 4'b0100;
    @(posedge clk); #1;
    slot_clr = 4'h0;
    slot_cs  = 4'b0100;
    wait_req(seen);
    checks++; if (seen !== 1'b1 || sdram_addr !== 23'h3002) $display("FAIL clr_req: seen %b addr %h want 1 3002", seen, sdram_addr); else passed++;
    sdram_ack = 1'b1;
    @(posedge clk); #1;
    sdram_ack = 1'b0;
    data_rdy  = 1'b1;
    data_read = 16'h1111;
    slot_clr  = 4'b0100;
    @(posedge clk); #1;
    slot_clr  = 4'h0;
    data_read = 16'h2222;
    @(posedge clk); #1;
    data_rdy  = 1'b0;
    @(negedge clk);
    checks++; if (slot_ok[2] !== 1'b0) $display("FAIL clr_ok_stays0: got %b want 0", slot_ok[2]); else passed++;
    serve(16'h3333, 16'h4444, seen, a, dropped);
    checks++; if (seen !== 1'b1 || a !== 23'h3002) $display("FAIL clr_rerequest: seen %b addr %h want 1 3002", seen, a); else passed++;
    checks++; if (slot_ok[2] !== 1'b1 || slot_dout[95:64] !== 32'h44443333) $display("FAIL clr_refill: ok %b dout %h want 1 44443333", slot_ok[2], slot_dout[95:64]); else passed++;
  endtask

  task automatic test_byte_select();
    int reqs;
    logic seen;
    @(posedge clk); #1;
    b_offset     = '0;
    b_addr[21:0] = 22'h7;
    b_cs         = 2'b01;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b_req) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (seen !== 1'b1 || b_sdram_addr !== 23'h3) $display("FAIL b8_addr: seen %b addr %h want 1 3", seen, b_sdram_addr); else passed++;
    b_ack = 1'b1;
    @(posedge clk); #1;
    b_ack  = 1'b0;
    b_rdy  = 1'b1;
    b_read = 16'hBEEF;
    @(posedge clk); #1;
    b_rdy  = 1'b0;
    @(negedge clk);
    checks++; if (b_ok[0] !== 1'b1 || b_dout[7:0] !== 8'hBE) $display("FAIL b8_odd: ok %b dout %h want 1 be", b_ok[0], b_dout[7:0]); else passed++;
    @(posedge clk); #1;
    b_addr[21:0] = 22'h6;
    @(negedge clk);
    checks++; if (b_ok[0] !== 1'b1 || b_dout[7:0] !== 8'hEF) $display("FAIL b8_even: ok %b dout %h want 1 ef", b_ok[0], b_dout[7:0]); else passed++;
    reqs = 0;
    repeat (5) begin
      @(negedge clk);
      if (b_req) reqs++;
    end
    checks++; if (reqs !== 0) $display("FAIL b8_no_req: reqs %0d want 0", reqs); else passed++;
  endtask

  task automatic test_reset_in_req();
    logic seen, dropped;
    logic [22:0] a;
    clear_all();
    slot_cs = 4'b0001;
    serve(16'h0, 16'h0, seen, a, dropped);
    @(posedge clk); #1;
    slot_cs = 4'b0011;
    wait_req(seen);
    checks++; if (seen !== 1'b1 || sdram_addr !== 23'h2001) $display("FAIL rst_pre_req: seen %b addr %h want 1 2001", seen, sdram_addr); else passed++;
    checks++; if (slot_ok !== 4'b0001) $display("FAIL rst_pre_ok: got %b want 0001", slot_ok); else passed++;
    #2;
    rst_n   = 1'b0;
    slot_cs = 4'b0101;
    #1;
    checks++; if (sdram_req !== 1'b0 || slot_ok !== 4'h0) $display("FAIL rst_immediate: req %b ok %b want 0 0000", sdram_req, slot_ok); else passed++;
    checks++; if (sdram_addr !== 23'h0) $display("FAIL rst_addr: got %h want 0", sdram_addr); else passed++;
    @(negedge clk); rst_n = 1'b1;
    serve(16'h0, 16'h0, seen, a, dropped);
    checks++; if (seen !== 1'b1 || a !== 23'h1000) $display("FAIL rst_rearb: seen %b addr %h want 1 1000", seen, a); else passed++;
    serve(16'h0, 16'h0, seen, a, dropped);
    checks++; if (seen !== 1'b1 || a !== 23'h3002) $display("FAIL rst_next: seen %b addr %h want 1 3002", seen, a); else passed++;
  endtask

  task automatic test_wrap();
    logic seen, dropped;
    logic [22:0] a;
    clear_all();
    set_slot(0, 22'h2, 23'h7FFFFF);
    slot_cs = 4'b0001;
    serve(16'h0, 16'h0, seen, a, dropped);
    checks++; if (seen !== 1'b1 || a !== 23'h1) $display("FAIL wrap_addr: seen %b addr %h want 1 1", seen, a); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    slot_cs = '0; slot_clr = '0; slot_addr = '0; offset = '0;
    sdram_ack = 1'b0; data_dst = 1'b0; data_rdy = 1'b0; data_read = '0;
    b_cs = '0; b_clr = '0; b_addr = '0; b_offset = '0;
    b_ack = 1'b0; b_rdy = 1'b0; b_read = '0;
    test_reset();
    test_miss_refill();
    test_round_robin();
    test_clear_midflight();
    test_byte_select();
    test_reset_in_req();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/jtcps_rom_nslots.md
JTCPS_ROM_NSLOTS -- requirements
Module: jtcps_rom_nslots

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- SDRAMW, 23, SDRAM word-address width.
- SLOTS, 4, number of read slots; legal range 1..8.
- AW, 22, slot address width, identical for all slots.
- DW, 32, slot data width, identical for all slots; legal values 8, 16, 32.
REQ-002 Clocking and reset: one clock; reset asynchronous, active-low.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- slot_cs, in, SLOTS, per-slot read request.
- slot_clr, in, SLOTS, per-slot cache invalidate.
- slot_addr, in, SLOTS*AW, packed slot addresses; slot i at [i*AW +: AW].
- offset, in, SLOTS*SDRAMW, packed per-slot SDRAM base offsets.
- slot_ok, out, SLOTS, data valid for the current address.
- slot_dout, out, SLOTS*DW, packed slot data.
- sdram_addr, out, SDRAMW, SDRAM word address.
- sdram_req, out, 1, SDRAM read request.
- sdram_ack, in, 1, request accepted by the controller.
- data_dst, in, 1, first data beat arriving next cycle; informational, unused.
- data_rdy, in, 1, data_read valid this cycle.
- data_read, in, 16, SDRAM read data.

Function
REQ-004 SDRAM address computation:
- DW=16 and DW=32: sdram_addr SHALL be offset_i + zero-extended slot_addr_i, modulo 2^SDRAMW.
- DW=8: sdram_addr SHALL be offset_i + slot_addr_i[AW-1:1], modulo 2^SDRAMW.
REQ-005 Each slot SHALL hold one cache entry: valid bit, tag (the issued address; for DW=8, addr[AW-1:1]) and data.
REQ-006 Hit definition: hit_i = valid_i and tag_i equals the current slot_addr_i (compared as per REQ-005).
- slot_ok_i = slot_cs_i & hit_i, combinational, zero-cycle latency.
REQ-007 Byte select for DW=8: slot_dout_i = slot_addr_i[0] ? data[15:8] : data[7:0].
REQ-008 FSM states SHALL be IDLE, REQ and WAIT.
REQ-009 IDLE: the candidate set is {i : slot_cs_i & ~hit_i & ~slot_clr_i}.
- Grant the first candidate at or after index ptr, wrapping modulo SLOTS.
- On grant: latch slot index and address, set ptr = (grant+1) mod SLOTS, enter REQ next cycle.
REQ-010 REQ: sdram_req=1 and sdram_addr held stable.
- On sdram_ack: sdram_req=0 in the next cycle, enter WAIT.
REQ-011 WAIT, beats:
- Each data_rdy captures one data_read beat.
- DW=8 and DW=16 need 1 beat.
- DW=32 needs 2 beats: the first fills [15:0], the second fills [31:16]; a beat counter resets on entry to WAIT.
REQ-012 On the final beat: write tag and data of the granted slot, set valid, return to IDLE.
- slot_ok may rise the cycle after the final beat.
REQ-013 slot_clr_i clears valid_i on the next edge.
- If slot_clr_i is asserted at any time while slot i is granted, the result SHALL be discarded and valid_i left 0.
REQ-014 If slot_cs_i drops or slot_addr_i changes mid-transaction, the transaction SHALL complete and cache the latched address.
- slot_ok_i then follows REQ-006 only.
REQ-015 A slot whose tag mismatches SHALL keep its old data on slot_dout until refilled; only slot_ok gates use.
REQ-016 At most one SDRAM transaction SHALL be outstanding; sdram_req SHALL never assert outside REQ.
REQ-017 When simultaneous data_rdy and slot_clr target the granted slot, the clear wins.

Reset
REQ-018 While rst_n=0 the block SHALL force the following immediately:
- state=IDLE, ptr=0, all valid=0, beat counter=0.
- sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0.
REQ-019 Reset asserted mid-transaction SHALL abandon it; after release the first action is a fresh arbitration in IDLE.

Verification
REQ-020 Bench SHALL cover:
- Miss and refill: SLOTS=4, DW=32, offset1=0x100, addr1=0x10, cs1=1. Expect sdram_addr=0x110 with req; after ack, rdy beats 0x1234 then 0xABCD, slot_dout1=0xABCD1234 and ok1=1; a repeat read hits with no new req.
- Round robin: cs0..cs3 all missing at once. Grants SHALL occur in order 0,1,2,3; a second round starting with ptr=2 SHALL grant 2,3,0,1.
- Clear mid-flight: slot2 granted and slot_clr2 pulsed during WAIT. After the final beat ok2 stays 0 and slot2 is re-requested.
- DW=8 byte select: offset=0, addr=0x7 issues sdram_addr=0x3; data_read=0xBEEF gives dout=0xBE; addr 0x6 then hits with dout 0xEF and no req.
- Reset in REQ: rst_n low while sdram_req=1. sdram_req=0 and all ok=0 immediately; after release the pending cs re-arbitrates from ptr=0.
- Wrap: offset=2^23-1, addr=2 gives sdram_addr=1.
